// File: rtl/fir_mac_bank.sv
// fir_mac_bank: per-bank FIR multiply-accumulate stage fed by one coefficient RAM bank.
// Define FIR_MAC_SATURATION_EN to clamp the partial sum to OUT_W and add the oSat flag.
module fir_mac_bank #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 3,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 23,
  parameter int OUT_W  = 16
) (
  input  logic                     iClk_12M,
  input  logic                     iRsn,
  input  logic                     iEnSample600k,
  input  logic                     iUpdateFlag,
  input  logic                     iEnDelay,
  input  logic signed [DATA_W-1:0] iFirIn,
  input  logic [3:0]               iInSel,
  input  logic                     iMacEn,
  input  logic signed [COEF_W-1:0] iCoeff,
  output logic signed [OUT_W-1:0]  oMacOut,
  output logic                     oMacValid,
  output logic                     oBusy
`ifdef FIR_MAC_SATURATION_EN
  ,
  output logic                     oSat
`endif
);

  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  tap_q [TAPS];
  logic signed [DATA_W-1:0]  tap_d [TAPS];
  logic [3:0]                sel_q, sel_d;
  logic                      vld_q, vld_d;
  logic [4:0]                cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [OUT_W-1:0]   mac_out_q, mac_out_d;
  logic                      mac_valid_q, mac_valid_d;
  logic                      busy_q, busy_d;
`ifdef FIR_MAC_SATURATION_EN
  logic                      sat_q, sat_d;
  logic                      clamp_s;
`endif

  logic signed [DATA_W-1:0]  tap_sel_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [OUT_W-1:0]   res_s;
  logic                      term_ok_s;

  // Delay chain shifts on iEnDelay independent of the MAC state.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      tap_d[k] = tap_q[k];
    end
    if (iEnDelay) begin
      tap_d[0] = iFirIn;
      for (int k = 1; k < TAPS; k++) begin
        tap_d[k] = tap_q[k-1];
      end
    end else begin
      tap_d[0] = tap_q[0];
    end
  end

  // Stage-2 datapath: tap select, full-width product, running sum and output conversion.
  always_comb begin
    tap_sel_s = {DATA_W{1'b0}};
    for (int k = 0; k < TAPS; k++) begin
      if (sel_q == 4'(k)) begin
        tap_sel_s = tap_q[k];
      end else begin
        tap_sel_s = tap_sel_s;
      end
    end
    term_ok_s = ({1'b0, sel_q} < 5'(TAPS));
    prod_s    = tap_sel_s * iCoeff;
    sum_s     = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
`ifdef FIR_MAC_SATURATION_EN
    // Overflow whenever the bits above the output sign bit are not a pure sign extension.
    clamp_s = (|sum_s[ACC_W-1:OUT_W-1]) && !(&sum_s[ACC_W-1:OUT_W-1]);
    if (clamp_s) begin
      res_s = sum_s[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      res_s = sum_s[OUT_W-1:0];
    end
`else
    res_s = sum_s[OUT_W-1:0];
`endif
  end

  // Frame FSM: update flag beats frame strobe, which beats the final accumulate.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    vld_d       = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mac_out_d   = mac_out_q;
    mac_valid_d = 1'b0;
`ifdef FIR_MAC_SATURATION_EN
    sat_d       = 1'b0;
`endif
    if (iUpdateFlag) begin
      state_d = IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = 5'd0;
    end else if (iEnSample600k) begin
      state_d = ACCUM;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCUM: begin
          vld_d = iMacEn;
          if (iMacEn) begin
            sel_d = iInSel;
          end else begin
            sel_d = sel_q;
          end
          if (vld_q && term_ok_s) begin
            acc_d = sum_s;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(TAPS-1)) begin
              state_d     = DONE;
              mac_out_d   = res_s;
              mac_valid_d = 1'b1;
`ifdef FIR_MAC_SATURATION_EN
              sat_d       = clamp_s;
`endif
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == ACCUM);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state_q     <= IDLE;
      for (int k = 0; k < TAPS; k++) begin
        tap_q[k] <= {DATA_W{1'b0}};
      end
      sel_q       <= 4'd0;
      vld_q       <= 1'b0;
      cnt_q       <= 5'd0;
      acc_q       <= {ACC_W{1'b0}};
      mac_out_q   <= {OUT_W{1'b0}};
      mac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIR_MAC_SATURATION_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      for (int k = 0; k < TAPS; k++) begin
        tap_q[k] <= tap_d[k];
      end
      sel_q       <= sel_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mac_out_q   <= mac_out_d;
      mac_valid_q <= mac_valid_d;
      busy_q      <= busy_d;
`ifdef FIR_MAC_SATURATION_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign oMacOut   = mac_out_q;
  assign oMacValid = mac_valid_q;
  assign oBusy     = busy_q;
`ifdef FIR_MAC_SATURATION_EN
  assign oSat      = sat_q;
`endif

endmodule

// File: tb/tb_fir_mac_bank.sv
// Self-checking bench for fir_mac_bank: constant-frame table, hand-written corner sequences,
// and random frames checked against a frame-level arithmetic model of the bank.
module tb_fir_mac_bank;
  localparam int TAPS = 10;

  logic clk = 1'b0;
  always #42 clk = ~clk;

  logic               rsn, en_sample, upd, en_delay, mac_en;
  logic signed [2:0]  fir_in;
  logic [3:0]         in_sel;
  logic signed [15:0] coeff;
  logic signed [15:0] mac_out;
  logic               mac_valid, busy;
`ifdef FIR_MAC_SATURATION_EN
  logic               sat;
`endif

  fir_mac_bank dut (
    .iClk_12M(clk), .iRsn(rsn), .iEnSample600k(en_sample), .iUpdateFlag(upd),
    .iEnDelay(en_delay), .iFirIn(fir_in), .iInSel(in_sel), .iMacEn(mac_en),
    .iCoeff(coeff), .oMacOut(mac_out), .oMacValid(mac_valid), .oBusy(busy)
`ifdef FIR_MAC_SATURATION_EN
    , .oSat(sat)
`endif
  );

  typedef struct {
    int          tap;
    int          coef;
    logic [15:0] exp_wrap;
    logic [15:0] exp_clamp;
    bit          exp_sat;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur     = "init";
  int    mtap [TAPS];
  logic signed [15:0] exp_out = 16'sd0;
  int    f_sel[$];
  int    f_coef[$];
  bit    f_den[$];
  int    f_din[$];

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got %0d expected %0d", cur, name, got, exp);
    end
  endtask

  // Frame result conversion from the plain integer sum.
  function automatic logic [16:0] conv(input longint s);
    logic [63:0] u;
    u = s;
`ifdef FIR_MAC_SATURATION_EN
    if (s > 32767) return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else return {1'b0, u[15:0]};
`else
    return {1'b0, u[15:0]};
`endif
  endfunction

  task automatic idle_inputs();
    en_sample = 1'b0; upd = 1'b0; en_delay = 1'b0; mac_en = 1'b0;
    fir_in = 3'sd0; in_sel = 4'd0; coeff = 16'sd0;
  endtask

  // One clock; the model delay line follows what was driven into this edge.
  task automatic tick();
    bit sh; bit r; int din;
    sh = en_delay; r = rsn; din = fir_in;
    @(posedge clk); #1;
    if (!r) begin
      for (int k = 0; k < TAPS; k++) mtap[k] = 0;
    end else if (sh) begin
      for (int k = TAPS-1; k > 0; k--) mtap[k] = mtap[k-1];
      mtap[0] = din;
    end
  endtask

  task automatic preload(input bit rnd, input int v);
    for (int k = 0; k < TAPS; k++) begin
      en_delay = 1'b1;
      fir_in = rnd ? 3'($urandom) : 3'(v);
      tick();
    end
    en_delay = 1'b0;
  endtask

  task automatic clear_frame();
    f_sel.delete(); f_coef.delete(); f_den.delete(); f_din.delete();
  endtask

  task automatic const_frame(input int c);
    clear_frame();
    for (int k = 0; k < TAPS; k++) begin f_sel.push_back(k); f_coef.push_back(c); end
    for (int k = 0; k < TAPS + 2; k++) begin f_den.push_back(1'b0); f_din.push_back(0); end
  endtask

  // Strobe, then issue f_sel/f_coef back to back and check every cycle.
  task automatic run_frame(input int abort_cyc, input bit collide, output logic signed [15:0] got_out);
    int n, cnt; longint sum; bit done, fin_now, cut, exp_v; logic [16:0] cv;
    n = f_sel.size();
    en_sample = 1'b1; tick(); en_sample = 1'b0;
    check("busy_start", busy, 1);
    cnt = 0; sum = 0; done = 1'b0; got_out = mac_out; cv = 17'd0;
    for (int i = 0; i <= n + 1; i++) begin
      mac_en   = (i < n);
      in_sel   = (i < n) ? 4'(f_sel[i]) : 4'd0;
      coeff    = (i >= 1 && i <= n) ? 16'(f_coef[i-1]) : 16'($urandom);
      en_delay = f_den[i];
      fir_in   = 3'(f_din[i]);
      upd      = (i == abort_cyc);
      cut      = (abort_cyc >= 0) && (i >= abort_cyc);
      fin_now  = 1'b0;
      if (i >= 1 && i <= n && !done && !cut && f_sel[i-1] < TAPS) begin
        sum += longint'(mtap[f_sel[i-1]]) * longint'(f_coef[i-1]);
        cnt++;
        if (cnt == TAPS) begin done = 1'b1; fin_now = 1'b1; end
      end
      if (collide && fin_now) en_sample = 1'b1;
      tick();
      en_sample = 1'b0; upd = 1'b0;
      exp_v = fin_now && !collide;
      if (exp_v) begin cv = conv(sum); exp_out = cv[15:0]; end
      check("valid", mac_valid, exp_v);
      check("out", mac_out, exp_out);
`ifdef FIR_MAC_SATURATION_EN
      check("sat", sat, exp_v ? cv[16] : 1'b0);
`endif
      check("busy", busy, (cut || (done && !collide)) ? 0 : 1);
      if (exp_v) got_out = mac_out;
    end
    idle_inputs();
  endtask

  vec_t vecs [6];
  logic signed [15:0] got;
  int cnt_r, s;

  initial begin
    vecs[0] = '{ 1,    100, 16'h03E8, 16'h03E8, 1'b0};
    vecs[1] = '{-4,  32767, 16'h0028, 16'h8000, 1'b1};
    vecs[2] = '{ 3,     -1, 16'hFFE2, 16'hFFE2, 1'b0};
    vecs[3] = '{-1,   1000, 16'hD8F0, 16'hD8F0, 1'b0};
    vecs[4] = '{ 3,  32767, 16'hFFE2, 16'h7FFF, 1'b1};
    vecs[5] = '{ 2, -32768, 16'h0000, 16'h8000, 1'b1};
    for (int k = 0; k < TAPS; k++) mtap[k] = 0;

    // Reset with random inputs.
    cur = "reset";
    rsn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en_sample = 1'($urandom); upd = 1'($urandom); en_delay = 1'($urandom);
      mac_en = 1'($urandom); fir_in = 3'($urandom); in_sel = 4'($urandom); coeff = 16'($urandom);
      tick();
    end
    check("out", mac_out, 0);
    check("valid", mac_valid, 0);
    check("busy", busy, 0);
`ifdef FIR_MAC_SATURATION_EN
    check("sat", sat, 0);
`endif
    rsn = 1'b1; idle_inputs(); tick();
    check("busy_idle", busy, 0);

    // Constant-tap, constant-coefficient frames from the table.
    for (int v = 0; v < 6; v++) begin
      cur = $sformatf("table%0d", v);
      preload(1'b0, vecs[v].tap);
      const_frame(vecs[v].coef);
      run_frame(-1, 1'b0, got);
`ifdef FIR_MAC_SATURATION_EN
      check("table_out", got, $signed(vecs[v].exp_clamp));
`else
      check("table_out", got, $signed(vecs[v].exp_wrap));
`endif
    end

    // Reset mid-frame: outputs return to zero and no valid appears.
    cur = "reset_mid";
    preload(1'b0, 1);
    en_sample = 1'b1; tick(); en_sample = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mac_en = 1'b1; in_sel = 4'(k); coeff = 16'sd100; tick();
    end
    rsn = 1'b0; tick(); rsn = 1'b1;
    check("out", mac_out, 0);
    check("busy", busy, 0);
    exp_out = 16'sd0;
    for (int k = 5; k < 12; k++) begin
      mac_en = (k < TAPS); in_sel = 4'(k); coeff = 16'sd100; tick();
      check("valid", mac_valid, 0);
      check("busy_after", busy, 0);
    end
    idle_inputs();
    preload(1'b0, 1);
    const_frame(100);
    run_frame(-1, 1'b0, got);
    check("fresh_out", got, 1000);

    // Update flag after five accumulated terms; flag also masks a strobe.
    cur = "abort";
    preload(1'b0, 2);
    const_frame(7);
    run_frame(6, 1'b0, got);
    check("held", mac_out, 1000);
    upd = 1'b1; en_sample = 1'b1; tick(); idle_inputs();
    check("busy_masked", busy, 0);
    const_frame(7);
    run_frame(-1, 1'b0, got);
    check("fresh_out", got, 140);

    // Strobe collides with the final accumulate: restart wins.
    cur = "collide";
    const_frame(-5);
    run_frame(-1, 1'b1, got);
    check("held", mac_out, 140);
    const_frame(-5);
    run_frame(-1, 1'b0, got);
    check("next_out", got, -100);

    // Shift during the first add uses the old tap; next frame sees tap0 = 3.
    cur = "shift_mac";
    preload(1'b0, 1);
    const_frame(100);
    f_den[1] = 1'b1; f_din[1] = 3;
    run_frame(-1, 1'b0, got);
    check("out", got, 1000);
    clear_frame();
    for (int k = 0; k < TAPS; k++) begin f_sel.push_back(0); f_coef.push_back(1); end
    for (int k = 0; k < TAPS + 2; k++) begin f_den.push_back(1'b0); f_din.push_back(0); end
    run_frame(-1, 1'b0, got);
    check("tap0_out", got, 30);

    // Extra reads in DONE change nothing.
    cur = "done_extra";
    for (int k = 0; k < 3; k++) begin
      mac_en = 1'b1; in_sel = 4'($urandom_range(0, 9)); coeff = 16'($urandom); tick();
      check("valid", mac_valid, 0);
      check("out", mac_out, 30);
    end
    idle_inputs();

    // Random frames: random taps, coefficients, out-of-range selects and shifts.
    for (int f = 0; f < 25; f++) begin
      cur = $sformatf("rand%0d", f);
      preload(1'b1, 0);
      clear_frame();
      cnt_r = 0;
      while (cnt_r < TAPS) begin
        s = int'($urandom_range(0, 15));
        if (s < TAPS) cnt_r++;
        f_sel.push_back(s);
        f_coef.push_back(int'($signed(16'($urandom))));
      end
      for (int k = 0; k < f_sel.size() + 2; k++) begin
        f_den.push_back(($urandom_range(0, 3) == 0));
        f_din.push_back(int'($signed(3'($urandom))));
      end
      run_frame(-1, 1'b0, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_mac_bank.md
Name: fir_mac_bank

Overview:
- Per-bank multiply-accumulate stage directly downstream of the coefficient-access FSM/arbiter and one coefficient RAM bank.
- Holds a TAPS-deep sample delay chain.
- Each sample frame, multiplies the FSM-sequenced coefficient stream (iCoeff, selected by iInSel) with the matching delayed sample, sums all TAPS products, and emits one partial sum per frame to the final four-bank adder.
- Four instances are used, one per RAM bank.

Parameters:
- TAPS, 10, taps handled by this bank (max 16, iInSel range).
- DATA_W, 3, signed sample width.
- COEF_W, 16, signed coefficient width.
- ACC_W, 23, accumulator width (DATA_W+COEF_W+ceil(log2 TAPS)).
- OUT_W, 16, signed output width.

Ports:
- iClk_12M  in  1  system clock, 12 MHz.
- iRsn  in  1  reset, synchronous, active-low.
- iEnSample600k  in  1  one-cycle frame-start strobe, every 20 clocks.
- iUpdateFlag  in  1  coefficient update phase; high aborts/blocks MAC.
- iEnDelay  in  1  delay-chain shift enable (FSM oEnDelay).
- iFirIn  in  DATA_W  signed input sample.
- iInSel  in  4  tap index issued with the RAM read (FSM oInSel).
- iMacEn  in  1  active-high: RAM read issued this cycle for this bank (inverse of bank Csn while update flag low).
- iCoeff  in  COEF_W  signed RAM read data, valid one cycle after iMacEn.
- oMacOut  out  OUT_W  signed bank partial sum, held between frames.
- oMacValid  out  1  one-cycle pulse when oMacOut updates.
- oBusy  out  1  high in ACCUM state.

Behaviour:
- Clock and reset: single clock iClk_12M. Reset is synchronous, active-low on iRsn, sampled at the iClk_12M rising edge.
- Reset values:
  - All delay taps = 0, accumulator = 0, term counter = 0.
  - oMacOut = 0, oMacValid = 0, oBusy = 0.
  - State = IDLE, pipeline valid = 0.
- Delay chain:
  - On iEnDelay=1: tap[0] <= iFirIn, tap[k] <= tap[k-1].
  - Shifts regardless of state and iUpdateFlag.
  - Products always use the tap values registered before the current edge.
- Pipeline, two stages:
  - Stage 1 (iMacEn=1 in ACCUM): sel_d <= iInSel, vld_d <= 1.
  - Stage 2 (vld_d=1): acc <= acc + sign-extended (iCoeff * tap[sel_d]), with a full DATA_W+COEF_W signed product.
  - If sel_d >= TAPS: the term is ignored (no add, not counted).
- State machine IDLE / ACCUM / DONE:
  - IDLE -> ACCUM: on iEnSample600k=1 and iUpdateFlag=0. Clears acc, counter, and vld_d.
  - ACCUM: each counted stage-2 term increments the counter. When the counter reaches TAPS on a stage-2 add:
    - oMacOut <= result(acc+last product), converted per the Optional Feature.
    - oMacValid=1 on the following cycle, for exactly 1 cycle.
    - Next state DONE.
  - Latency: last iMacEn -> oMacValid = 2 clocks.
  - DONE: iMacEn ignored. iEnSample600k -> ACCUM (same clears as from IDLE).
  - ACCUM with iEnSample600k before the counter reaches TAPS: restart the frame. The partial sum is discarded, no valid is emitted, and oMacOut holds.
- iEnSample600k in the same cycle as the final stage-2 add: the restart wins. No valid is emitted, oMacOut holds.
- iUpdateFlag=1 in any state: next state IDLE, acc/counter/vld_d cleared, oMacOut holds, oMacValid=0. iEnSample600k is ignored while the flag is high.
- oBusy = (state==ACCUM).
- Extra iMacEn after the TAPS count completes (state DONE): no effect.

Optional Feature:
- Macro: FIR_MAC_SATURATION_EN.
- Defined: the result is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (for OUT_W=16: -32768..32767) when converting acc to oMacOut. oSat (1-bit output, reset 0) is added; it pulses 1 together with oMacValid when clamping occurred.
- Undefined: oMacOut = acc[OUT_W-1:0] (two's-complement wrap), and oSat does not exist.

Test Plan:
- Reset: drive iRsn=0 for 3 clocks with random inputs -> all outputs 0, state IDLE. Check that an iRsn deassert mid-frame clears acc, with no valid emitted.
- Basic frame: taps preloaded 1,2,...,10 (values wrap within 3-bit signed as per input: use +1 all), coefficients all 100, iMacEn for iInSel 0..9 on consecutive cycles -> oMacOut=1000, oMacValid exactly 1 clock, 2 clocks after the last iMacEn.
- Signed: all taps -4, coefficients 0x7FFF, 10 terms -> acc=-1310680. Without the macro, oMacOut=16'h0028 (wrap). With FIR_MAC_SATURATION_EN, oMacOut=-32768 and oSat=1.
- Abort: iUpdateFlag=1 after 5 terms -> no oMacValid, oMacOut holds its previous value, state IDLE. A later iEnSample600k with the flag low gives a correct fresh frame.
- Restart collision: iEnSample600k coincides with the 10th stage-2 add -> no valid; the next full frame yields a correct sum.
- Delay shift during MAC: iEnDelay pulses while ACCUM with iFirIn=3 -> a product issued the same cycle uses the old tap value. Check tap[0]=3 on the next frame.
